// File: rtl/qkv_stream_loader.sv
// Stream loader for the 8x8 PE attention top. It packs key/query/value words from one
// valid/ready stream into three operand buses, then runs the PE for one job.
module qkv_stream_loader #(
    parameter int unsigned DW      = 16,
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    output logic [DW*N-1:0] key,
    output logic [DW*N-1:0] query,
    output logic [DW*N-1:0] value,
    output logic            pe_en,
    output logic            pe_rst_n,
    input  logic            pe_all_done,
    output logic            busy,
    output logic            job_done,
    output logic            load_err,
    output logic            timeout
);

    localparam int unsigned BW = DW * N;
    localparam int unsigned CW = $clog2(3 * N);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] NCnt     = CW'(N);
    localparam logic [CW-1:0] N2Cnt    = CW'(2 * N);
    localparam logic [CW-1:0] LastCnt  = CW'(3 * N - 1);
    localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StLoad, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] key_q, query_q, value_q;
    logic          s_ready_q, pe_en_q, pe_rst_n_q, busy_q;
    logic          job_done_q, load_err_q, timeout_q;
    logic          load_err_d, timeout_d;
    logic          beat, last_cnt;
    logic [1:0]    bank;
    logic [CW-1:0] word_idx;

    // s_ready_q tracks state LOAD, so a beat can only occur while loading.
    assign beat     = s_valid & s_ready_q;
    assign last_cnt = (cnt_q == LastCnt);

    always_comb begin
        bank     = 2'd0;
        word_idx = cnt_q;
        if (cnt_q >= N2Cnt) begin
            bank     = 2'd2;
            word_idx = cnt_q - N2Cnt;
        end else if (cnt_q >= NCnt) begin
            bank     = 2'd1;
            word_idx = cnt_q - NCnt;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        load_err_d = 1'b0;
        timeout_d  = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (beat) begin
                    if (s_last && last_cnt) begin
                        cnt_d   = '0;
                        timer_d = '0;
                        state_d = StRun;
                    end else if (s_last != last_cnt) begin
                        // Framing error: restart the job from word 0.
                        cnt_d      = '0;
                        load_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                timer_d = timer_q + 1'b1;
                if (pe_all_done) begin
                    state_d = StDone;
                end else if ((TIMEOUT != 0) && (timer_q == TimerMax)) begin
                    state_d   = StLoad;
                    timeout_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StLoad;
                cnt_d   = '0;
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            cnt_q      <= '0;
            timer_q    <= '0;
            s_ready_q  <= 1'b0;
            pe_en_q    <= 1'b0;
            pe_rst_n_q <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            load_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            s_ready_q  <= (state_d == StLoad);
            pe_en_q    <= 1'b1;
            pe_rst_n_q <= (state_d == StRun);
            busy_q     <= (state_d == StRun);
            job_done_q <= (state_d == StDone);
            load_err_q <= load_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q   <= '0;
            query_q <= '0;
            value_q <= '0;
        end else if (beat) begin
            unique case (bank)
                2'd0:    key_q[word_idx*DW +: DW]   <= s_data;
                2'd1:    query_q[word_idx*DW +: DW] <= s_data;
                2'd2:    value_q[word_idx*DW +: DW] <= s_data;
                default: ;
            endcase
        end
    end

    assign s_ready  = s_ready_q;
    assign key      = key_q;
    assign query    = query_q;
    assign value    = value_q;
    assign pe_en    = pe_en_q;
    assign pe_rst_n = pe_rst_n_q;
    assign busy     = busy_q;
    assign job_done = job_done_q;
    assign load_err = load_err_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_qkv_stream_loader.sv
// Directed bench for qkv_stream_loader: loading, framing errors, completion,
// timeout and asynchronous reset aborts.
module tb_qkv_stream_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s_valid, s_ready, s_last;
    logic [15:0]  s_data;
    logic [511:0] key, query, value;
    logic         pe_en, pe_rst_n, pe_all_done, busy, job_done, load_err, timeout;

    int errors = 0;
    int checks = 0;
    int jd_cnt = 0;
    int le_cnt = 0;
    int to_cnt = 0;

    qkv_stream_loader #(.DW(16), .N(32), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .key         (key),
        .query       (query),
        .value       (value),
        .pe_en       (pe_en),
        .pe_rst_n    (pe_rst_n),
        .pe_all_done (pe_all_done),
        .busy        (busy),
        .job_done    (job_done),
        .load_err    (load_err),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (job_done) jd_cnt++;
            if (load_err) le_cnt++;
            if (timeout)  to_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [511:0] got,
                            input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] ramp(input logic [15:0] base);
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = base + 16'(i);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word i goes to bank i/32, slice i%32; data = bank base + slice index.
    task automatic send_job(input logic [15:0] kb, input logic [15:0] qb,
                            input logic [15:0] vb, input int nwords,
                            input int last_idx, input bit gaps);
        for (int i = 0; i < nwords; i++) begin
            int wait_cyc;
            if (gaps && ($urandom_range(1) == 1)) begin
                s_valid = 1'b0;
                tick();
            end
            wait_cyc = 0;
            while (!s_ready && wait_cyc < 200) begin
                tick();
                wait_cyc++;
            end
            if (!s_ready) check_eq("ready_wait", 512'(s_ready), 512'(1));
            s_data  = ((i / 32) == 0) ? kb + 16'(i % 32) :
                      ((i / 32) == 1) ? qb + 16'(i % 32) : vb + 16'(i % 32);
            s_last  = (i == last_idx);
            s_valid = 1'b1;
            tick();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic check_bus(input string tag, input logic [15:0] kb,
                             input logic [15:0] qb, input logic [15:0] vb);
        check_eq({tag, "_key"}, key, ramp(kb));
        check_eq({tag, "_query"}, query, ramp(qb));
        check_eq({tag, "_value"}, value, ramp(vb));
    endtask

    task automatic finish_job(input string tag);
        int jd0;
        jd0 = jd_cnt;
        pe_all_done = 1'b1;
        tick();
        pe_all_done = 1'b0;
        check_eq({tag, "_job_done"}, 512'(job_done), 512'(1));
        check_eq({tag, "_done_rst_n"}, 512'(pe_rst_n), 512'(0));
        tick();
        check_eq({tag, "_ready_after"}, 512'(s_ready), 512'(1));
        check_eq({tag, "_jd_count"}, 512'(jd_cnt - jd0), 512'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 512'(s_ready), 512'(0));
        check_eq({tag, "_pe_en"}, 512'(pe_en), 512'(0));
        check_eq({tag, "_pe_rst_n"}, 512'(pe_rst_n), 512'(0));
        check_eq({tag, "_flags"}, 512'({busy, job_done, load_err, timeout}), 512'(0));
        check_eq({tag, "_key"}, key, '0);
        check_eq({tag, "_value"}, value, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int jd0, le0, to0;
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        pe_all_done = 1'b0;
        #3;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("post_reset_ready", 512'(s_ready), 512'(1));
        check_eq("post_reset_pe", 512'({pe_en, pe_rst_n, busy}), 512'(3'b100));

        // Back-to-back job, then junk offered during RUN must not be taken.
        send_job(16'h0000, 16'h1000, 16'h2000, 96, 95, 1'b0);
        check_eq("run_entry", 512'({busy, pe_rst_n, s_ready, pe_en}), 512'(4'b1101));
        check_bus("job1", 16'h0000, 16'h1000, 16'h2000);
        s_valid = 1'b1;
        s_data  = 16'hDEAD;
        s_last  = 1'b1;
        repeat (5) tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (35) tick();
        check_eq("run_c40_busy", 512'(busy), 512'(1));
        check_bus("no_beat_in_run", 16'h0000, 16'h1000, 16'h2000);
        check_eq("no_err_in_run", 512'(le_cnt), 512'(0));
        finish_job("job1");
        check_eq("job1_no_timeout", 512'(to_cnt), 512'(0));

        send_job(16'hA000, 16'hA020, 16'hA040, 96, 95, 1'b0);
        check_bus("job2", 16'hA000, 16'hA020, 16'hA040);
        finish_job("job2");

        send_job(16'h0000, 16'h1000, 16'h2000, 96, 95, 1'b1);
        check_eq("gap_busy", 512'(busy), 512'(1));
        check_bus("gap", 16'h0000, 16'h1000, 16'h2000);
        finish_job("gap");

        // Early s_last on beat 10.
        le0 = le_cnt;
        send_job(16'h5000, 16'h5100, 16'h5200, 11, 10, 1'b0);
        check_eq("early_last_err", 512'({load_err, busy, s_ready}), 512'(3'b101));
        tick();
        check_eq("early_last_pulse", 512'({load_err, busy}), 512'(0));
        check_eq("early_last_count", 512'(le_cnt - le0), 512'(1));
        send_job(16'h0100, 16'h1100, 16'h2100, 96, 95, 1'b0);
        check_bus("after_early", 16'h0100, 16'h1100, 16'h2100);
        finish_job("after_early");

        // Missing s_last on beat 95; a full follow-up job proves cnt restarted at 0.
        le0 = le_cnt;
        send_job(16'h6000, 16'h6100, 16'h6200, 96, -1, 1'b0);
        check_eq("no_last_err", 512'({load_err, busy, s_ready}), 512'(3'b101));
        tick();
        check_eq("no_last_count", 512'(le_cnt - le0), 512'(1));
        send_job(16'h3000, 16'h3100, 16'h3200, 96, 95, 1'b0);
        check_bus("after_no_last", 16'h3000, 16'h3100, 16'h3200);
        finish_job("after_no_last");

        // Timeout with all_done held low: RUN cycles 0..63, pulse in cycle 64.
        jd0 = jd_cnt;
        to0 = to_cnt;
        send_job(16'h0000, 16'h1000, 16'h2000, 96, 95, 1'b0);
        repeat (63) tick();
        check_eq("to_c63", 512'({busy, timeout}), 512'(2'b10));
        tick();
        check_eq("to_c64", 512'({timeout, busy, s_ready, pe_rst_n}), 512'(4'b1010));
        tick();
        check_eq("to_after", 512'(timeout), 512'(0));
        check_eq("to_count", 512'(to_cnt - to0), 512'(1));
        check_eq("to_no_done", 512'(jd_cnt - jd0), 512'(0));

        // all_done at timer 63 beats the expiry.
        to0 = to_cnt;
        send_job(16'h0000, 16'h1000, 16'h2000, 96, 95, 1'b0);
        repeat (63) tick();
        finish_job("race");
        check_eq("race_no_timeout", 512'(to_cnt - to0), 512'(0));

        // Asynchronous reset after beat 50 of a load.
        send_job(16'h4000, 16'h4100, 16'h4200, 50, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_load");
        tick();
        rst_n = 1'b1;
        tick();
        send_job(16'h0000, 16'h1000, 16'h2000, 96, 95, 1'b0);
        check_bus("after_rst_load", 16'h0000, 16'h1000, 16'h2000);
        finish_job("after_rst_load");

        // Asynchronous reset mid-RUN: no pulse follows.
        send_job(16'h7000, 16'h7100, 16'h7200, 96, 95, 1'b0);
        repeat (5) tick();
        jd0 = jd_cnt;
        le0 = le_cnt;
        to0 = to_cnt;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_run");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("rst_run_no_pulse", 512'((jd_cnt - jd0) + (le_cnt - le0) + (to_cnt - to0)),
                 512'(0));
        send_job(16'h0200, 16'h1200, 16'h2200, 96, 95, 1'b1);
        check_bus("after_rst_run", 16'h0200, 16'h1200, 16'h2200);
        finish_job("after_rst_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
